// File: rtl/decode_stage_if.sv
// decode_stage_if: ID/EX bus between the decode stage and the execute stage.
//   master (decode)  : drives ex_valid and the ex_* payload/control, samples ex_ready
//   slave  (execute) : samples ex_valid and ex_*, drives ex_ready
interface decode_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [2:0]  ex_funct3;
  logic [3:0]  ex_alu_op;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_jal;
  logic        ex_jalr;
  logic        ex_alu_src_imm;
  logic        ex_alu_src_pc;
  logic        ex_illegal;

  modport master (
    output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_rs1, ex_rs2,
           ex_funct3, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
           ex_jal, ex_jalr, ex_alu_src_imm, ex_alu_src_pc, ex_illegal,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rd, ex_rs1, ex_rs2,
           ex_funct3, ex_alu_op, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch,
           ex_jal, ex_jalr, ex_alu_src_imm, ex_alu_src_pc, ex_illegal,
    output ex_ready
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: RV32I instruction decode with an ID/EX pipeline register.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   if_valid, if_instr, if_pc     instruction from fetch
//   id_ready                      stage accepts if_* this cycle
//   rf_read_reg1/2, rf_read_data1/2  register-file read port (combinational data)
//   flush                         drop ID/EX contents and the current input
//   ex                            ID/EX bus (master side), ex_ready comes back on it
// Parameter LOAD_USE_STALL: 1 inserts a bubble on load-use, 0 leaves it to forwarding.
module decode_stage #(
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_valid,
  input  logic [31:0]           if_instr,
  input  logic [31:0]           if_pc,
  output logic                  id_ready,
  output logic [4:0]            rf_read_reg1,
  output logic [4:0]            rf_read_reg2,
  input  logic [31:0]           rf_read_data1,
  input  logic [31:0]           rf_read_data2,
  input  logic                  flush,
  decode_stage_if.master        ex
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  // alt selects SUB on funct3=000 and SRA on funct3=101
  function automatic logic [3:0] funct3_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  funct3_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  funct3_op = ALU_SLL;
      3'b010:  funct3_op = ALU_SLT;
      3'b011:  funct3_op = ALU_SLTU;
      3'b100:  funct3_op = ALU_XOR;
      3'b101:  funct3_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  funct3_op = ALU_OR;
      default: funct3_op = ALU_AND;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [31:0] d_imm;
  logic [3:0]  d_alu_op;
  logic        d_use_rs1, d_use_rs2;
  logic        d_reg_write, d_mem_read, d_mem_write, d_branch, d_jal, d_jalr;
  logic        d_alu_src_imm, d_alu_src_pc, d_illegal;
  logic [4:0]  d_rs1, d_rs2, d_rd;

  logic        advance, hazard;

  assign opcode = if_instr[6:0];
  assign funct3 = if_instr[14:12];
  assign imm_i  = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s  = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b  = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                   if_instr[11:8], 1'b0};
  assign imm_u  = {if_instr[31:12], 12'b0};
  assign imm_j  = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                   if_instr[30:21], 1'b0};

  assign rf_read_reg1 = if_instr[19:15];
  assign rf_read_reg2 = if_instr[24:20];

  always_comb begin
    d_imm         = 32'd0;
    d_alu_op      = ALU_ADD;
    d_use_rs1     = 1'b0;
    d_use_rs2     = 1'b0;
    d_reg_write   = 1'b0;
    d_mem_read    = 1'b0;
    d_mem_write   = 1'b0;
    d_branch      = 1'b0;
    d_jal         = 1'b0;
    d_jalr        = 1'b0;
    d_alu_src_imm = 1'b0;
    d_alu_src_pc  = 1'b0;
    d_illegal     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        d_reg_write = 1'b1; d_alu_src_imm = 1'b1; d_imm = imm_u; d_alu_op = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        d_reg_write = 1'b1; d_alu_src_imm = 1'b1; d_alu_src_pc = 1'b1; d_imm = imm_u;
      end
      OPC_JAL: begin
        d_reg_write = 1'b1; d_jal = 1'b1; d_alu_src_imm = 1'b1; d_alu_src_pc = 1'b1;
        d_imm = imm_j;
      end
      OPC_JALR: begin
        d_reg_write = 1'b1; d_jalr = 1'b1; d_alu_src_imm = 1'b1; d_use_rs1 = 1'b1;
        d_imm = imm_i;
      end
      OPC_BRANCH: begin
        d_branch = 1'b1; d_use_rs1 = 1'b1; d_use_rs2 = 1'b1; d_imm = imm_b;
        d_alu_op = ALU_SUB;
      end
      OPC_LOAD: begin
        d_reg_write = 1'b1; d_mem_read = 1'b1; d_alu_src_imm = 1'b1; d_use_rs1 = 1'b1;
        d_imm = imm_i;
      end
      OPC_STORE: begin
        d_mem_write = 1'b1; d_alu_src_imm = 1'b1; d_use_rs1 = 1'b1; d_use_rs2 = 1'b1;
        d_imm = imm_s;
      end
      OPC_OPIMM: begin
        // instr[30] is part of the immediate except on shift-right, where it picks SRAI
        d_reg_write = 1'b1; d_alu_src_imm = 1'b1; d_use_rs1 = 1'b1; d_imm = imm_i;
        d_alu_op = funct3_op(funct3, (funct3 == 3'b101) && if_instr[30]);
      end
      OPC_OP: begin
        d_reg_write = 1'b1; d_use_rs1 = 1'b1; d_use_rs2 = 1'b1;
        d_alu_op = funct3_op(funct3, if_instr[30]);
      end
      default: d_illegal = 1'b1;
    endcase
  end

  assign d_rs1 = d_use_rs1 ? if_instr[19:15] : 5'd0;
  assign d_rs2 = d_use_rs2 ? if_instr[24:20] : 5'd0;
  assign d_rd  = d_reg_write ? if_instr[11:7] : 5'd0;

  assign advance = !ex.ex_valid || ex.ex_ready;
  // Unused sources are already zeroed, so ex_rd!=0 keeps them from matching.
  assign hazard  = LOAD_USE_STALL && if_valid && ex.ex_valid && ex.ex_mem_read &&
                   (ex.ex_rd != 5'd0) && ((ex.ex_rd == d_rs1) || (ex.ex_rd == d_rs2));
  assign id_ready = !rst && (flush || (advance && !hazard));

  always_ff @(posedge clk) begin
    if (rst) begin
      ex.ex_valid       <= 1'b0;
      ex.ex_pc          <= 32'd0;
      ex.ex_rs1_data    <= 32'd0;
      ex.ex_rs2_data    <= 32'd0;
      ex.ex_imm         <= 32'd0;
      ex.ex_rd          <= 5'd0;
      ex.ex_rs1         <= 5'd0;
      ex.ex_rs2         <= 5'd0;
      ex.ex_funct3      <= 3'd0;
      ex.ex_alu_op      <= 4'd0;
      ex.ex_reg_write   <= 1'b0;
      ex.ex_mem_read    <= 1'b0;
      ex.ex_mem_write   <= 1'b0;
      ex.ex_branch      <= 1'b0;
      ex.ex_jal         <= 1'b0;
      ex.ex_jalr        <= 1'b0;
      ex.ex_alu_src_imm <= 1'b0;
      ex.ex_alu_src_pc  <= 1'b0;
      ex.ex_illegal     <= 1'b0;
    end else if (flush || (advance && hazard)) begin
      // bubble: payload may keep stale values, control flags must clear
      ex.ex_valid       <= 1'b0;
      ex.ex_reg_write   <= 1'b0;
      ex.ex_mem_read    <= 1'b0;
      ex.ex_mem_write   <= 1'b0;
      ex.ex_branch      <= 1'b0;
      ex.ex_jal         <= 1'b0;
      ex.ex_jalr        <= 1'b0;
      ex.ex_alu_src_imm <= 1'b0;
      ex.ex_alu_src_pc  <= 1'b0;
      ex.ex_illegal     <= 1'b0;
    end else if (advance) begin
      ex.ex_valid       <= if_valid;
      ex.ex_pc          <= if_pc;
      ex.ex_rs1_data    <= d_use_rs1 ? rf_read_data1 : 32'd0;
      ex.ex_rs2_data    <= d_use_rs2 ? rf_read_data2 : 32'd0;
      ex.ex_imm         <= d_imm;
      ex.ex_rd          <= d_rd;
      ex.ex_rs1         <= d_rs1;
      ex.ex_rs2         <= d_rs2;
      ex.ex_funct3      <= funct3;
      ex.ex_alu_op      <= d_alu_op;
      ex.ex_reg_write   <= if_valid && d_reg_write;
      ex.ex_mem_read    <= if_valid && d_mem_read;
      ex.ex_mem_write   <= if_valid && d_mem_write;
      ex.ex_branch      <= if_valid && d_branch;
      ex.ex_jal         <= if_valid && d_jal;
      ex.ex_jalr        <= if_valid && d_jalr;
      ex.ex_alu_src_imm <= if_valid && d_alu_src_imm;
      ex.ex_alu_src_pc  <= if_valid && d_alu_src_pc;
      ex.ex_illegal     <= if_valid && d_illegal;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        flush;
  logic        ex_ready;
  logic [31:0] rf_read_data1, rf_read_data2;
  logic        id_ready_a, id_ready_b;
  logic [4:0]  rf_read_reg1_a, rf_read_reg2_a, rf_read_reg1_b, rf_read_reg2_b;
  int          total = 0;
  int          bad = 0;

  decode_stage_if ex_a ();
  decode_stage_if ex_b ();

  assign ex_a.ex_ready = ex_ready;
  assign ex_b.ex_ready = ex_ready;

  decode_stage #(.LOAD_USE_STALL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready_a), .rf_read_reg1(rf_read_reg1_a), .rf_read_reg2(rf_read_reg2_a),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2), .flush(flush),
    .ex(ex_a.master)
  );

  decode_stage #(.LOAD_USE_STALL(1'b0)) dut_b (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready_b), .rf_read_reg1(rf_read_reg1_b), .rf_read_reg2(rf_read_reg2_b),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2), .flush(flush),
    .ex(ex_b.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
  endtask

  initial begin
    rst = 1'b1; if_valid = 1'b0; if_instr = 32'h0; if_pc = 32'h0;
    flush = 1'b0; ex_ready = 1'b1;
    rf_read_data1 = 32'h1111_0001; rf_read_data2 = 32'h2222_0002;
    tick(); tick();
    chk("rst_valid", ex_a.ex_valid, 0);
    chk("rst_regw", ex_a.ex_reg_write, 0);
    chk("rst_pc", ex_a.ex_pc, 0);
    chk("rst_imm", ex_a.ex_imm, 0);
    chk("rst_ready", id_ready_a, 0);

    // addi x1,x0,5
    rst = 1'b0;
    present(32'h0050_0093, 32'h100);
    #1 chk("addi_ready", id_ready_a, 1);
    tick();
    chk("addi_valid", ex_a.ex_valid, 1);
    chk("addi_rd", ex_a.ex_rd, 1);
    chk("addi_imm", ex_a.ex_imm, 5);
    chk("addi_op", ex_a.ex_alu_op, 0);
    chk("addi_srcimm", ex_a.ex_alu_src_imm, 1);
    chk("addi_regw", ex_a.ex_reg_write, 1);
    chk("addi_pc", ex_a.ex_pc, 32'h100);

    // lw x2,0(x1) then add x3,x2,x1
    present(32'h0000_A103, 32'h104);
    tick();
    chk("lw_rd", ex_a.ex_rd, 2);
    chk("lw_mrd", ex_a.ex_mem_read, 1);
    chk("lw_rs1data", ex_a.ex_rs1_data, 32'h1111_0001);
    present(32'h0011_01B3, 32'h108);
    #1;
    chk("add_rfreg1", rf_read_reg1_a, 2);
    chk("add_rfreg2", rf_read_reg2_a, 1);
    chk("lu_ready_stall", id_ready_a, 0);
    chk("lu_ready_nostall", id_ready_b, 1);
    tick();
    chk("lu_bubble_valid", ex_a.ex_valid, 0);
    chk("lu_bubble_regw", ex_a.ex_reg_write, 0);
    chk("lu_bubble_mrd", ex_a.ex_mem_read, 0);
    chk("lu_after_ready", id_ready_a, 1);
    chk("nostall_valid", ex_b.ex_valid, 1);
    chk("nostall_rs1", ex_b.ex_rs1, 2);
    tick();
    chk("lu_add_valid", ex_a.ex_valid, 1);
    chk("lu_add_rs1", ex_a.ex_rs1, 2);
    chk("lu_add_rs2", ex_a.ex_rs2, 1);
    chk("lu_add_rd", ex_a.ex_rd, 3);
    chk("lu_add_op", ex_a.ex_alu_op, 0);
    if_valid = 1'b0;
    tick();
    chk("idle_valid", ex_a.ex_valid, 0);

    // sw x5,-4(x2)
    present(32'hFE51_2E23, 32'h10C);
    tick();
    chk("sw_imm", ex_a.ex_imm, 32'hFFFF_FFFC);
    chk("sw_mwr", ex_a.ex_mem_write, 1);
    chk("sw_regw", ex_a.ex_reg_write, 0);
    chk("sw_rs2", ex_a.ex_rs2, 5);
    chk("sw_rs1", ex_a.ex_rs1, 2);
    chk("sw_rd", ex_a.ex_rd, 0);

    // sub x5,x6,x7 held under backpressure
    present(32'h4073_02B3, 32'h110);
    tick();
    chk("sub_op", ex_a.ex_alu_op, 1);
    ex_ready = 1'b0;
    present(32'h0050_0093, 32'h114);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", id_ready_a, 0);
      tick();
      chk("bp_valid", ex_a.ex_valid, 1);
      chk("bp_op", ex_a.ex_alu_op, 1);
      chk("bp_rd", ex_a.ex_rd, 5);
      chk("bp_rs2", ex_a.ex_rs2, 7);
      chk("bp_pc", ex_a.ex_pc, 32'h110);
    end
    ex_ready = 1'b1;
    #1 chk("bp_release_ready", id_ready_a, 1);
    tick();
    chk("bp_next_op", ex_a.ex_alu_op, 0);
    chk("bp_next_pc", ex_a.ex_pc, 32'h114);

    // flush while backpressured
    ex_ready = 1'b0;
    flush = 1'b1;
    present(32'hFFFF_FFFF, 32'h118);
    #1 chk("flush_ready", id_ready_a, 1);
    tick();
    flush = 1'b0;
    chk("flush_valid", ex_a.ex_valid, 0);
    chk("flush_regw", ex_a.ex_reg_write, 0);

    // illegal word
    ex_ready = 1'b1;
    tick();
    chk("ill_valid", ex_a.ex_valid, 1);
    chk("ill_flag", ex_a.ex_illegal, 1);
    chk("ill_flags", {ex_a.ex_reg_write, ex_a.ex_mem_read, ex_a.ex_mem_write,
                      ex_a.ex_branch, ex_a.ex_jal, ex_a.ex_jalr}, 0);

    // flush during a load-use stall
    present(32'h0000_A103, 32'h11C);
    tick();
    present(32'h0011_01B3, 32'h120);
    #1 chk("fs_stall_ready", id_ready_a, 0);
    flush = 1'b1;
    #1 chk("fs_flush_ready", id_ready_a, 1);
    tick();
    flush = 1'b0;
    if_valid = 1'b0;
    chk("fs_valid", ex_a.ex_valid, 0);
    chk("fs_mrd", ex_a.ex_mem_read, 0);

    // reset mid-stall
    present(32'h0000_A103, 32'h124);
    tick();
    present(32'h0011_01B3, 32'h128);
    rst = 1'b1;
    #1 chk("rs_ready", id_ready_a, 0);
    tick();
    chk("rs_valid", ex_a.ex_valid, 0);
    chk("rs_ready2", id_ready_a, 0);
    chk("rs_rd", ex_a.ex_rd, 0);
    rst = 1'b0;
    present(32'h0050_0093, 32'h200);
    tick();
    chk("rs_resume_valid", ex_a.ex_valid, 1);
    chk("rs_resume_rd", ex_a.ex_rd, 1);
    chk("rs_resume_pc", ex_a.ex_pc, 32'h200);

    // lui x1,0x12345
    present(32'h1234_50B7, 32'h204);
    tick();
    chk("lui_imm", ex_a.ex_imm, 32'h1234_5000);
    chk("lui_op", ex_a.ex_alu_op, 10);
    chk("lui_rs1", ex_a.ex_rs1, 0);

    // jal x1,8
    present(32'h0080_00EF, 32'h208);
    tick();
    chk("jal_imm", ex_a.ex_imm, 8);
    chk("jal_flag", ex_a.ex_jal, 1);
    chk("jal_srcpc", ex_a.ex_alu_src_pc, 1);

    // srai x1,x1,1
    present(32'h4010_D093, 32'h20C);
    tick();
    chk("srai_op", ex_a.ex_alu_op, 7);
    chk("srai_f3", ex_a.ex_funct3, 5);
    if_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
